// File: rtl/rd_id_ex_reg_if.sv
// ID/EX stage bus: decode-side fields, later-stage forwarding sources and the
// registered ALU/MEM-facing outputs. The master side drives the *_i fields.
interface rd_id_ex_reg_if #(
  parameter int XLEN  = 64,
  parameter int RADDR = 5
);
  logic             valid_i;
  logic [XLEN-1:0]  rs1_data_i, rs2_data_i, imm_i;
  logic [RADDR-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [3:0]       instruction_i;
  logic [1:0]       ALUop_i;
  logic             ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
  logic             stall_i, flush_i;
  logic [RADDR-1:0] exmem_rd_i, memwb_rd_i;
  logic             exmem_regwrite_i, memwb_regwrite_i;
  logic [XLEN-1:0]  exmem_result_i, memwb_result_i;

  logic [XLEN-1:0]  A_o, B_o, store_data_o;
  logic [3:0]       instruction_o;
  logic [1:0]       ALUop_o;
  logic [RADDR-1:0] rd_o;
  logic             RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, valid_o;
  logic             load_use_o;

  modport master (
    output valid_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
           instruction_i, ALUop_i, ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i,
           MemtoReg_i, stall_i, flush_i, exmem_rd_i, memwb_rd_i, exmem_regwrite_i,
           memwb_regwrite_i, exmem_result_i, memwb_result_i,
    input  A_o, B_o, store_data_o, instruction_o, ALUop_o, rd_o, RegWrite_o,
           MemRead_o, MemWrite_o, MemtoReg_o, valid_o, load_use_o
  );

  modport slave (
    input  valid_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
           instruction_i, ALUop_i, ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i,
           MemtoReg_i, stall_i, flush_i, exmem_rd_i, memwb_rd_i, exmem_regwrite_i,
           memwb_regwrite_i, exmem_result_i, memwb_result_i,
    output A_o, B_o, store_data_o, instruction_o, ALUop_o, rd_o, RegWrite_o,
           MemRead_o, MemWrite_o, MemtoReg_o, valid_o, load_use_o
  );
endinterface

// File: rtl/rd_id_ex_reg.sv
// ID/EX pipeline register with load-use detection and EX/MEM, MEM/WB operand
// forwarding. Forwarding muxes exist only when RD_FWD_EN is defined.
module rd_id_ex_reg #(
  parameter int XLEN  = 64,
  parameter int RADDR = 5
) (
  input logic          clk_i,
  input logic          rst_i,
  rd_id_ex_reg_if.slave bus
);
  logic             load_use, bubble, load_en;
  logic             valid_reg, regwrite_reg, memread_reg, memwrite_reg, memtoreg_reg;
  logic             alusrc_reg;
  logic [1:0]       aluop_reg;
  logic [3:0]       instr_reg;
  logic [RADDR-1:0] rd_reg;
  logic [XLEN-1:0]  imm_reg;

  assign load_use = bus.valid_i & valid_reg & memread_reg & (rd_reg != '0) &
                    ((rd_reg == bus.rs1_addr_i) | (rd_reg == bus.rs2_addr_i));
  // Flush beats stall; a load-use bubble only goes in when the stage may advance.
  assign bubble  = bus.flush_i | (~bus.stall_i & load_use);
  assign load_en = ~bus.flush_i & ~bus.stall_i & ~load_use;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      aluop_reg    <= 2'b00;
      alusrc_reg   <= 1'b0;
      instr_reg    <= 4'h0;
      rd_reg       <= '0;
      imm_reg      <= '0;
    end else if (bubble) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      aluop_reg    <= 2'b00;
    end else if (load_en) begin
      valid_reg    <= bus.valid_i;
      regwrite_reg <= bus.valid_i & bus.RegWrite_i;
      memread_reg  <= bus.valid_i & bus.MemRead_i;
      memwrite_reg <= bus.valid_i & bus.MemWrite_i;
      memtoreg_reg <= bus.valid_i & bus.MemtoReg_i;
      aluop_reg    <= bus.valid_i ? bus.ALUop_i : 2'b00;
      alusrc_reg   <= bus.ALUSrc_i;
      instr_reg    <= bus.instruction_i;
      rd_reg       <= bus.rd_addr_i;
      imm_reg      <= bus.imm_i;
    end
  end

  // One operand slice per source register: gi = 0 is rs1, gi = 1 is rs2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic [XLEN-1:0] data_reg;
      logic [XLEN-1:0] fwd_val;

      always_ff @(posedge clk_i) begin
        if (rst_i)
          data_reg <= '0;
        else if (load_en)
          data_reg <= (gi == 0) ? bus.rs1_data_i : bus.rs2_data_i;
      end

`ifdef RD_FWD_EN
      logic [RADDR-1:0] addr_reg;

      always_ff @(posedge clk_i) begin
        if (rst_i)
          addr_reg <= '0;
        else if (load_en)
          addr_reg <= (gi == 0) ? bus.rs1_addr_i : bus.rs2_addr_i;
      end

      // EX/MEM holds the younger result, so it wins over MEM/WB; x0 never forwards.
      always_comb begin
        fwd_val = data_reg;
        if (bus.exmem_regwrite_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == addr_reg))
          fwd_val = bus.exmem_result_i;
        else if (bus.memwb_regwrite_i && (bus.memwb_rd_i != '0) && (bus.memwb_rd_i == addr_reg))
          fwd_val = bus.memwb_result_i;
      end
`else
      assign fwd_val = data_reg;
`endif
    end
  endgenerate

  assign bus.A_o           = g_src[0].fwd_val;
  assign bus.store_data_o  = g_src[1].fwd_val;
  assign bus.B_o           = alusrc_reg ? imm_reg : g_src[1].fwd_val;
  assign bus.instruction_o = instr_reg;
  assign bus.ALUop_o       = aluop_reg;
  assign bus.rd_o          = rd_reg;
  assign bus.RegWrite_o    = regwrite_reg;
  assign bus.MemRead_o     = memread_reg;
  assign bus.MemWrite_o    = memwrite_reg;
  assign bus.MemtoReg_o    = memtoreg_reg;
  assign bus.valid_o       = valid_reg;
  assign bus.load_use_o    = load_use;
endmodule

// File: tb/tb_rd_id_ex_reg.sv
// Directed table-driven bench for rd_id_ex_reg; one vector per clock cycle,
// load_use checked before the edge, registered outputs checked after it.
module tb_rd_id_ex_reg;
  localparam bit FWD =
`ifdef RD_FWD_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [63:0] rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [3:0]  instr;
    logic [1:0]  aluop;
    logic        alusrc, regwr, memrd, memwr;
    logic [4:0]  exrd, wbrd;
    logic        exwe, wbwe;
    logic [63:0] exres, wbres;
    logic        chk_lu, chk_data;
    logic        e_lu, e_valid, e_regwr, e_memrd, e_memwr;
    logic [1:0]  e_aluop;
    logic [3:0]  e_instr;
    logic [4:0]  e_rd;
    logic [63:0] e_a, e_b, e_st;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rd_id_ex_reg_if #(.XLEN(64), .RADDR(5)) bus ();
  rd_id_ex_reg #(.XLEN(64), .RADDR(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cur = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s vec %0d: got %h want %h", name, cur, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst                  = v.rst;
    bus.stall_i          = v.stall;
    bus.flush_i          = v.flush;
    bus.valid_i          = v.valid;
    bus.rs1_data_i       = v.rs1d;
    bus.rs2_data_i       = v.rs2d;
    bus.imm_i            = v.imm;
    bus.rs1_addr_i       = v.rs1a;
    bus.rs2_addr_i       = v.rs2a;
    bus.rd_addr_i        = v.rda;
    bus.instruction_i    = v.instr;
    bus.ALUop_i          = v.aluop;
    bus.ALUSrc_i         = v.alusrc;
    bus.RegWrite_i       = v.regwr;
    bus.MemRead_i        = v.memrd;
    bus.MemWrite_i       = v.memwr;
    bus.MemtoReg_i       = v.memrd;
    bus.exmem_rd_i       = v.exrd;
    bus.memwb_rd_i       = v.wbrd;
    bus.exmem_regwrite_i = v.exwe;
    bus.memwb_regwrite_i = v.wbwe;
    bus.exmem_result_i   = v.exres;
    bus.memwb_result_i   = v.wbres;
  endtask

  initial begin
    vec_t d, v;
    d = '{default: 0};
    d.chk_lu = 1'b1;
    d.chk_data = 1'b1;
    drive(d);
    rst = 1'b1;

    // Two reset cycles with a busy load on the inputs.
    v = d; v.rst = 1; v.valid = 1; v.rs1d = 64'hAAAA; v.rs2d = 64'hBBBB; v.rs1a = 5;
    v.rs2a = 5; v.rda = 5; v.memrd = 1; v.regwr = 1; v.aluop = 2; v.instr = 4'hF;
    v.chk_lu = 0; tbl.push_back(v);
    v.chk_lu = 1; tbl.push_back(v);
    // Plain pass-through.
    v = d; v.valid = 1; v.rs1a = 1; v.rs2a = 2; v.rda = 3; v.rs1d = 5; v.rs2d = 3;
    v.aluop = 2; v.regwr = 1;
    v.e_valid = 1; v.e_regwr = 1; v.e_rd = 3; v.e_aluop = 2; v.e_a = 5; v.e_b = 3; v.e_st = 3;
    tbl.push_back(v);
    // Both later stages match rs1: EX/MEM wins.
    v = d; v.valid = 1; v.rs1a = 7; v.rs2a = 8; v.rda = 9; v.rs1d = 64'h11; v.rs2d = 64'h22;
    v.regwr = 1; v.aluop = 2; v.exrd = 7; v.exwe = 1; v.exres = 64'h30;
    v.wbrd = 7; v.wbwe = 1; v.wbres = 64'h40;
    v.e_valid = 1; v.e_regwr = 1; v.e_rd = 9; v.e_aluop = 2;
    v.e_a = FWD ? 64'h30 : 64'h11; v.e_b = 64'h22; v.e_st = 64'h22;
    tbl.push_back(v);
    // Stalled, EX/MEM write-enable dropped: MEM/WB supplies rs1.
    v.stall = 1; v.exwe = 0; v.rs1d = 64'h77; v.rda = 13;
    v.e_a = FWD ? 64'h40 : 64'h11;
    tbl.push_back(v);
    // x0 sources never forward.
    v = d; v.valid = 1; v.rs1d = 64'h55; v.rs2d = 64'h66; v.rda = 4; v.regwr = 1; v.aluop = 2;
    v.exwe = 1; v.exres = 64'h30; v.wbwe = 1; v.wbres = 64'h40;
    v.e_valid = 1; v.e_regwr = 1; v.e_rd = 4; v.e_aluop = 2;
    v.e_a = 64'h55; v.e_b = 64'h66; v.e_st = 64'h66;
    tbl.push_back(v);
    // Store with immediate: B is imm, store data is forwarded rs2.
    v = d; v.valid = 1; v.rs1a = 1; v.rs1d = 1; v.rs2a = 6; v.rs2d = 64'h12;
    v.imm = 64'hFFFF_FFFF_FFFF_FFF0; v.alusrc = 1; v.memwr = 1; v.instr = 7;
    v.exrd = 6; v.exwe = 1; v.exres = 64'h99;
    v.e_valid = 1; v.e_memwr = 1; v.e_instr = 7; v.e_a = 1;
    v.e_b = 64'hFFFF_FFFF_FFFF_FFF0; v.e_st = FWD ? 64'h99 : 64'h12;
    tbl.push_back(v);
    // ld x5, then a user of x5 in rs2: bubble, then the re-presented instruction.
    v = d; v.valid = 1; v.memrd = 1; v.regwr = 1; v.rda = 5; v.rs1a = 2; v.rs1d = 64'h100;
    v.imm = 8; v.alusrc = 1; v.instr = 3;
    v.e_valid = 1; v.e_regwr = 1; v.e_memrd = 1; v.e_rd = 5; v.e_instr = 3;
    v.e_a = 64'h100; v.e_b = 8; v.e_st = 0;
    tbl.push_back(v);
    v = d; v.valid = 1; v.rs1a = 6; v.rs2a = 5; v.rs1d = 7; v.rda = 11; v.regwr = 1;
    v.aluop = 2; v.instr = 8; v.e_lu = 1; v.chk_data = 0;
    tbl.push_back(v);
    v.wbrd = 5; v.wbwe = 1; v.wbres = 64'hBEEF; v.e_lu = 0; v.chk_data = 1;
    v.e_valid = 1; v.e_regwr = 1; v.e_rd = 11; v.e_aluop = 2; v.e_instr = 8; v.e_a = 7;
    v.e_b = FWD ? 64'hBEEF : 64'h0; v.e_st = v.e_b;
    tbl.push_back(v);
    // Three stall cycles with new decode inputs: everything holds.
    v.stall = 1; v.rs1a = 3; v.rs1d = 64'hDEAD; v.rda = 12; v.memrd = 1;
    for (int i = 0; i < 3; i++) tbl.push_back(v);
    // Stall and flush together: bubble.
    v.flush = 1; v.chk_data = 0;
    v.e_valid = 0; v.e_regwr = 0; v.e_memrd = 0; v.e_aluop = 0;
    tbl.push_back(v);
    // Load-use while stalled holds; flush with load-use pending gives a bubble.
    v = d; v.valid = 1; v.memrd = 1; v.regwr = 1; v.rda = 5; v.rs1a = 2; v.rs1d = 64'h200;
    v.imm = 64'h10; v.alusrc = 1;
    v.e_valid = 1; v.e_regwr = 1; v.e_memrd = 1; v.e_rd = 5; v.e_a = 64'h200; v.e_b = 64'h10;
    tbl.push_back(v);
    v.stall = 1; v.memrd = 0; v.rs1a = 5; v.rs1d = 1; v.rda = 6; v.imm = 0; v.alusrc = 0;
    v.e_lu = 1;
    tbl.push_back(v);
    v.stall = 0; v.flush = 1; v.chk_data = 0;
    v.e_valid = 0; v.e_regwr = 0; v.e_memrd = 0;
    tbl.push_back(v);
    // A load to x0 never raises load_use.
    v = d; v.valid = 1; v.memrd = 1; v.regwr = 1; v.rs1a = 3; v.rs1d = 64'h300;
    v.e_valid = 1; v.e_regwr = 1; v.e_memrd = 1; v.e_a = 64'h300;
    tbl.push_back(v);
    v = d; v.valid = 1; v.rs1d = 64'h44; v.rda = 7; v.regwr = 1; v.aluop = 2;
    v.e_valid = 1; v.e_regwr = 1; v.e_rd = 7; v.e_aluop = 2; v.e_a = 64'h44;
    tbl.push_back(v);
    // valid_i = 0: controls captured as 0, data captured.
    v = d; v.regwr = 1; v.memrd = 1; v.memwr = 1; v.aluop = 2; v.instr = 5; v.rda = 8;
    v.rs1a = 1; v.rs1d = 9;
    v.e_rd = 8; v.e_instr = 5; v.e_a = 9;
    tbl.push_back(v);
    // ld x5 followed by an invalid slot reading x5: no load_use.
    v = d; v.valid = 1; v.memrd = 1; v.regwr = 1; v.rda = 5; v.rs1a = 2; v.rs1d = 64'h500;
    v.e_valid = 1; v.e_regwr = 1; v.e_memrd = 1; v.e_rd = 5; v.e_a = 64'h500;
    tbl.push_back(v);
    tbl.push_back(v);
    tbl[tbl.size()-1] = d;
    tbl[tbl.size()-1].rs1a = 5; tbl[tbl.size()-1].rs1d = 64'h600; tbl[tbl.size()-1].rda = 9;
    tbl[tbl.size()-1].e_rd = 9; tbl[tbl.size()-1].e_a = 64'h600;
    tbl.push_back(v);
    // Reset mid-operation with stall and a pending load-use: everything clears.
    v = d; v.rst = 1; v.stall = 1; v.valid = 1; v.rs2a = 5; v.rs1d = 64'h123; v.regwr = 1;
    v.e_lu = 1;
    tbl.push_back(v);

    foreach (tbl[i]) begin
      cur = i;
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk_lu) chk("load_use", 64'(bus.load_use_o), 64'(tbl[i].e_lu));
      @(posedge clk);
      #1;
      chk("valid", 64'(bus.valid_o), 64'(tbl[i].e_valid));
      chk("regwrite", 64'(bus.RegWrite_o), 64'(tbl[i].e_regwr));
      chk("memread", 64'(bus.MemRead_o), 64'(tbl[i].e_memrd));
      chk("memtoreg", 64'(bus.MemtoReg_o), 64'(tbl[i].e_memrd));
      chk("memwrite", 64'(bus.MemWrite_o), 64'(tbl[i].e_memwr));
      chk("aluop", 64'(bus.ALUop_o), 64'(tbl[i].e_aluop));
      if (tbl[i].chk_data) begin
        chk("rd", 64'(bus.rd_o), 64'(tbl[i].e_rd));
        chk("instr", 64'(bus.instruction_o), 64'(tbl[i].e_instr));
        chk("A", bus.A_o, tbl[i].e_a);
        chk("B", bus.B_o, tbl[i].e_b);
        chk("store", bus.store_data_o, tbl[i].e_st);
      end
      $display("vec %0d: lu=%0b valid=%0b rd=%0d A=%h B=%h st=%h", i, bus.load_use_o,
               bus.valid_o, bus.rd_o, bus.A_o, bus.B_o, bus.store_data_o);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/rd_id_ex_reg.md
Name: rd_id_ex_reg

Overview:
- ID/EX pipeline stage that sits directly upstream of rd_ALU_top.
- Registers decoded operands and control from the decode stage.
- Resolves EX-stage data hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and drives A_i, B_i, instruction_i and ALUop_i of the ALU.

Parameters:
XLEN, 64, datapath width; matches the ALU operand width.
RADDR, 5, register address width (32 architectural registers, x0 hardwired zero).

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous, active-high reset.
valid_i  input  1  decode stage presents a valid instruction.
rs1_data_i, rs2_data_i  input  XLEN  register file read data.
imm_i  input  XLEN  sign-extended immediate.
rs1_addr_i, rs2_addr_i, rd_addr_i  input  RADDR  source/destination register numbers.
instruction_i  input  4  {funct7[5], funct3}, passed to ALU control.
ALUop_i  input  2  00 add, 01 sub, 10 R-type decode, 11 reserved.
ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  input  1 each  decode control.
stall_i  input  1  downstream stall; hold all contents.
flush_i  input  1  branch/jump flush; kill the stage contents.
exmem_rd_i, memwb_rd_i  input  RADDR  destination registers of the later stages.
exmem_regwrite_i, memwb_regwrite_i  input  1  write enables of the later stages.
exmem_result_i, memwb_result_i  input  XLEN  forwardable results.
A_o, B_o  output  XLEN  ALU operands.
store_data_o  output  XLEN  forwarded rs2, sent to MEM.
instruction_o  output  4  to ALU.
ALUop_o  output  2  to ALU.
rd_o  output  RADDR  destination register.
RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, valid_o  output  1 each  registered control.
load_use_o  output  1  combinational; the decode stage and PC must hold this cycle.

Behaviour:
- Per-cycle update priority: rst_i > flush_i > stall_i > load_use_o > normal load.
- Reset:
  - valid_o, all control outputs, rd_o, instruction_o and ALUop_o are 0.
  - Registered data is 0, so A_o = B_o = store_data_o = 0.
  - Reset asserted mid-operation discards the contents on the next edge; no partial state survives.
- flush_i = 1: the next edge loads a bubble.
  - Bubble: valid = 0, RegWrite = MemRead = MemWrite = MemtoReg = 0, ALUop = 00.
  - Data fields in a bubble are don't-care but held.
  - flush_i overrides stall_i.
- stall_i = 1 (no flush): every register holds its value. load_use_o is still computed, but no bubble is inserted.
- load_use_o = valid_i & valid_o & MemRead_o & (rd_o != 0) & (rd_o == rs1_addr_i | rd_o == rs2_addr_i).
  - When load_use_o = 1 (no stall, no flush), the next edge inserts a bubble.
  - The decode stage re-presents the same instruction.
  - Next cycle MEM/WB forwarding supplies the loaded value.
- Normal load: all *_i fields are captured. valid_o = valid_i.
  - If valid_i = 0, the control fields are captured as 0.
- Latency: 1 cycle from decode inputs to registered outputs.
  - Forwarding muxes are combinational on the registered rs1/rs2 and the live exmem/memwb inputs.
- Forward select for source rsN (N = 1, 2):
  - EX/MEM if exmem_regwrite_i & exmem_rd_i != 0 & exmem_rd_i == rsN_q.
  - Else MEM/WB under the same rule.
  - Else the registered read data.
  - EX/MEM wins when both match. x0 is never forwarded; its operand is the registered value.
- Operand outputs:
  - A_o = fwd(rs1).
  - store_data_o = fwd(rs2).
  - B_o = ALUSrc_q ? imm_q : fwd(rs2).
- Outputs are a pure function of the registered state plus the forwarding inputs; no other combinational paths.

Optional Feature:
- RD_FWD_EN defined: forwarding muxes present as described above.
- RD_FWD_EN undefined:
  - A_o = rs1_data_q, store_data_o = rs2_data_q, B_o = ALUSrc_q ? imm_q : rs2_data_q.
  - The exmem/memwb inputs are ignored.
  - load_use_o logic is unchanged.
  - The compiler is responsible for inserting NOPs for other RAW hazards.

Test Plan:
1. Reset: rst_i = 1 for 2 cycles with arbitrary inputs -> valid_o = 0, RegWrite_o = 0, A_o = B_o = 0, load_use_o = 0.
2. Pass-through: rs1_data = 5, rs2_data = 3, ADD, ALUop = 10, ALUSrc = 0, no forwarding match -> next cycle A_o = 5, B_o = 3; downstream ALU C_o = 8.
3. Forwarding:
   - rs1_q = x7, exmem_rd = 7 with result 0x30, memwb_rd = 7 with result 0x40 -> A_o = 0x30.
   - Drop exmem_regwrite -> A_o = 0x40.
   - rs1 = x0 with exmem_rd = 0 -> A_o = registered value.
4. Load-use: ld x5 in the stage (MemRead_o = 1, rd_o = 5), next instruction has rs2 = x5 -> load_use_o = 1; next edge valid_o = 0, RegWrite_o = 0; the re-presented instruction is then accepted.
5. Stall vs flush:
   - stall_i = 1 for 3 cycles -> outputs held.
   - stall_i = 1 and flush_i = 1 together -> bubble loaded on that edge.
6. ALUSrc: imm = 0xFFFFFFFFFFFFFFF0, ALUSrc = 1, exmem forwarding rs2 = 0x99 -> B_o = imm, store_data_o = 0x99.
